// File: rtl/pipelined_data_memory_bhw.sv
// MEM-stage data memory: byte/half/word stores with lane masking, sign/zero-extended loads,
// alignment checking and an optional post-reset zero sweep. One edge, registered read.
module pipelined_data_memory_bhw #(
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemoryRead,
  input  logic                  MemoryWrite,
  input  logic [1:0]            AccessSize,
  input  logic                  LoadUnsigned,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  AddressError,
  output logic                  Busy
);
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WW;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          state_q;
  logic [WW-1:0]   clear_idx_q;
  logic            valid_q;
  logic            err_q;
  logic [1:0]      size_q;
  logic [1:0]      lane_q;
  logic            uns_q;

  logic [WW-1:0]   word_idx;
  logic [1:0]      lane;
  logic            misaligned;
  logic            ready;
  logic            clr_en;
  logic            wr_en;
  logic            rd_en;
  logic [3:0]      lane_mask;
  logic [31:0]     wr_bytes;
  logic [31:0]     rd_word;

  assign word_idx   = Address[ADDR_WIDTH-1:2];
  assign lane       = Address[1:0];
  assign misaligned = (AccessSize == 2'b11) ||
                      (AccessSize == 2'b01 && lane[0]) ||
                      (AccessSize == 2'b10 && lane != 2'b00);
  assign ready      = (state_q == S_READY) && !Reset;
  assign clr_en     = (state_q == S_CLEAR) && !Reset;
  // A simultaneous read+write performs only the write.
  assign wr_en      = ready && MemoryWrite && !misaligned;
  assign rd_en      = ready && MemoryRead && !MemoryWrite && !misaligned;
  assign Busy       = (state_q == S_CLEAR);
  assign ReadValid  = valid_q;
  assign AddressError = err_q;

  always_comb begin
    lane_mask = 4'b0000;
    wr_bytes  = WriteData;
    case (AccessSize)
      2'b00: begin
        lane_mask = 4'b0001 << lane;
        wr_bytes  = {4{WriteData[7:0]}};
      end
      2'b01: begin
        lane_mask = lane[1] ? 4'b1100 : 4'b0011;
        wr_bytes  = {2{WriteData[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  // One byte-wide RAM per lane so each lane infers its own block RAM with write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge Clock) begin
        if (clr_en)
          mem_q[clear_idx_q] <= 8'h00;
        else if (wr_en && lane_mask[gi])
          mem_q[word_idx] <= wr_bytes[8*gi +: 8];
      end

      always_ff @(posedge Clock) begin
        if (Reset)      rd_q <= 8'h00;
        else if (rd_en) rd_q <= mem_q[word_idx];
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clear_idx_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b10;
      lane_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clear_idx_q <= clear_idx_q + 1'b1;
          if (clear_idx_q == WW'(DEPTH - 1)) state_q <= S_READY;
        end
        default: begin
          if ((MemoryRead || MemoryWrite) && misaligned) begin
            err_q <= 1'b1;
          end else if (rd_en) begin
            valid_q <= 1'b1;
            size_q  <= AccessSize;
            lane_q  <= lane;
            uns_q   <= LoadUnsigned;
          end
        end
      endcase
    end
  end

  // Lane selection and extension sit after the RAM output register, so ReadData holds between loads.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  always_comb begin
    sel_b = rd_word[8*lane_q +: 8];
    sel_h = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   ReadData = uns_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   ReadData = uns_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: ReadData = rd_word;
    endcase
  end
endmodule

// File: tb/tb_pipelined_data_memory_bhw.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-array reference model.
module tb_pipelined_data_memory_bhw;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemoryRead = 1'b0;
  logic        MemoryWrite = 1'b0;
  logic [1:0]  AccessSize = 2'b10;
  logic        LoadUnsigned = 1'b0;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        AddressError;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_err;

  pipelined_data_memory_bhw #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .AccessSize(AccessSize),
    .LoadUnsigned(LoadUnsigned), .ReadData(ReadData), .ReadValid(ReadValid),
    .AddressError(AddressError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_bad(input logic [7:0] a, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] size, input logic uns);
    int n = nbytes(size);
    logic [63:0] v = 0;
    for (int i = 0; i < n; i++) v = v + (64'(model_mem[(int'(a) + i) % 256]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v + ((64'hFFFF_FFFF >> (8 * n)) << (8 * n));
    return v[31:0];
  endfunction

  // Drives one request for one edge and advances the reference model's expectations.
  task automatic op(input logic rd, input logic wr, input logic [7:0] a, input logic [1:0] size,
                    input logic uns, input logic [31:0] wd);
    logic dropped = Busy;
    Address = a; AccessSize = size; LoadUnsigned = uns; WriteData = wd;
    MemoryRead = rd; MemoryWrite = wr;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!dropped && (rd || wr)) begin
      if (is_bad(a, size)) exp_err = 1'b1;
      else if (wr) begin
        for (int i = 0; i < nbytes(size); i++)
          model_mem[(int'(a) + i) % 256] = wd[8*i +: 8];
      end else begin
        exp_valid = 1'b1;
        exp_data  = model_load(a, size, uns);
      end
    end
    @(posedge Clock); #1;
    MemoryRead = 1'b0; MemoryWrite = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int cnt = 0;
    while (Busy && cnt < 300) begin
      cnt++;
      @(posedge Clock); #1;
    end
    total++;
    if (cnt !== 64) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=64", name, cnt);
    end
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    total++;
    if (ReadData !== 32'h0 || ReadValid !== 1'b0 || AddressError !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL reset_state got rd=%h v=%b e=%b busy=%b want 0/0/0/1",
                      ReadData, ReadValid, AddressError, Busy);
    end
    Reset = 1'b0;
    count_busy("first_sweep");
    exp_data = 32'h0;
    for (int w = 0; w < 64; w++) op(1'b0, 1'b1, 8'(w * 4), 2'd2, 1'b0, $urandom | 32'h1);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    // Store attempted while the sweep is running must be lost.
    MemoryWrite = 1'b1; Address = 8'h08; AccessSize = 2'd2; WriteData = 32'hCAFEF00D;
    @(posedge Clock); #1;
    MemoryWrite = 1'b0;
    begin
      int cnt = 1;
      while (Busy && cnt < 300) begin
        cnt++;
        @(posedge Clock); #1;
      end
      total++;
      if (cnt !== 64) begin
        bad++; $display("FAIL resweep busy_cycles got=%0d want=64", cnt);
      end
    end
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    op(1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h0 || ReadValid !== 1'b1) begin
      bad++; $display("FAIL clear_0x00 got=%h v=%b want=00000000 v=1", ReadData, ReadValid);
    end
    op(1'b1, 1'b0, 8'hFC, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h0) begin
      bad++; $display("FAIL clear_0xFC got=%h want=00000000", ReadData);
    end
    op(1'b1, 1'b0, 8'h08, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h0) begin
      bad++; $display("FAIL busy_store_lost got=%h want=00000000", ReadData);
    end
  endtask

  task automatic test_byte_lanes;
    op(1'b0, 1'b1, 8'h10, 2'd2, 1'b0, 32'h11223344);
    op(1'b0, 1'b1, 8'h12, 2'd0, 1'b0, 32'h000000AA);
    op(1'b1, 1'b0, 8'h10, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h11AA3344 || ReadValid !== 1'b1) begin
      bad++; $display("FAIL byte_lane got=%h v=%b want=11aa3344 v=1", ReadData, ReadValid);
    end
  endtask

  task automatic test_sign_ext;
    logic [31:0] want [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00000001};
    logic [7:0]  addr [4] = '{8'h22, 8'h22, 8'h22, 8'h20};
    logic [1:0]  size [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic        uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    op(1'b0, 1'b1, 8'h20, 2'd2, 1'b0, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b0, addr[i], size[i], uns[i], 0);
      total++;
      if (ReadData !== want[i] || ReadValid !== 1'b1) begin
        bad++; $display("FAIL sign_ext[%0d] got=%h v=%b want=%h v=1", i, ReadData, ReadValid, want[i]);
      end
    end
  endtask

  task automatic test_misalign;
    logic       rd [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ad [3] = '{8'h31, 8'h33, 8'h30};
    logic [1:0] sz [3] = '{2'd2, 2'd1, 2'd3};
    op(1'b0, 1'b1, 8'h30, 2'd2, 1'b0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      op(rd[i], !rd[i], ad[i], sz[i], 1'b0, 32'hDEADBEEF);
      total++;
      if (AddressError !== 1'b1 || ReadValid !== 1'b0) begin
        bad++; $display("FAIL misalign[%0d] got err=%b v=%b want err=1 v=0", i, AddressError, ReadValid);
      end
    end
    op(1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 0);
    total++;
    if (AddressError !== 1'b0) begin
      bad++; $display("FAIL err_pulse got=%b want=0", AddressError);
    end
    op(1'b1, 1'b0, 8'h30, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h12345678) begin
      bad++; $display("FAIL misalign_nowrite got=%h want=12345678", ReadData);
    end
  endtask

  task automatic test_back_to_back;
    op(1'b0, 1'b1, 8'h40, 2'd2, 1'b0, 32'h5);
    op(1'b1, 1'b0, 8'h40, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h5 || ReadValid !== 1'b1) begin
      bad++; $display("FAIL b2b_load got=%h v=%b want=00000005 v=1", ReadData, ReadValid);
    end
    op(1'b1, 1'b1, 8'h44, 2'd2, 1'b0, 32'h99);
    total++;
    if (ReadValid !== 1'b0 || ReadData !== 32'h5) begin
      bad++; $display("FAIL rw_both got=%h v=%b want=00000005 v=0", ReadData, ReadValid);
    end
    op(1'b1, 1'b0, 8'h44, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h99) begin
      bad++; $display("FAIL rw_both_write got=%h want=00000099", ReadData);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] kind = 2'($urandom_range(0, 3));
      logic [1:0] sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      logic [7:0] a = 8'($urandom_range(0, 31));
      logic       rd = kind[0];
      logic       wr = kind[1] && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd2) ? 8'h3 : (sz == 2'd1) ? 8'h1 : 8'h0);
      op(rd, wr, a, sz, 1'($urandom), $urandom);
      total++;
      if (ReadValid !== exp_valid || AddressError !== exp_err || ReadData !== exp_data) begin
        bad++; $display("FAIL random[%0d] got=%h v=%b e=%b want=%h v=%b e=%b", n,
                        ReadData, ReadValid, AddressError, exp_data, exp_valid, exp_err);
      end
    end
  endtask

  task automatic test_reset_midsweep;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (30) @(posedge Clock);
    #1;
    total++;
    if (Busy !== 1'b1) begin
      bad++; $display("FAIL midsweep_busy got=%b want=1", Busy);
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    count_busy("midsweep_restart");
    exp_data = 32'h0;
    op(1'b1, 1'b0, 8'h10, 2'd2, 1'b0, 0);
    total++;
    if (ReadData !== 32'h0) begin
      bad++; $display("FAIL midsweep_clear got=%h want=00000000", ReadData);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    exp_data = 32'h0; exp_valid = 1'b0; exp_err = 1'b0;
    test_reset;
    test_byte_lanes;
    test_sign_ext;
    test_misalign;
    test_back_to_back;
    test_random;
    test_reset_midsweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_data_memory_bhw.md
# pipelined_data_memory_bhw

Parametrised data memory for the MEM stage of the pipelined MIPS datapath. Supports byte/halfword/word stores with lane masking, sign- or zero-extending loads, alignment checking, and a post-reset clear sweep. Reads and writes both occur on the rising clock edge with registered read data, replacing the split-edge 32x64 memory. Sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- ADDR_WIDTH, 8, byte-address width; word count DEPTH = 2^(ADDR_WIDTH-2) (default 64 words = 256 bytes)
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the sweep
- Clock  in  1  single system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high
- Address  in  ADDR_WIDTH  byte address; bits [ADDR_WIDTH-1:2] select the word, [1:0] the lane
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- MemoryRead  in  1  load request this cycle
- MemoryWrite  in  1  store request this cycle
- AccessSize  in  2  00 byte, 01 half, 10 word, 11 reserved
- LoadUnsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- ReadData  out  32  registered load result
- ReadValid  out  1  ReadData updated at the last edge
- AddressError  out  1  last request was misaligned or reserved-size; one-cycle pulse
- Busy  out  1  clear sweep in progress; requests ignored

## Operation
- States: CLEAR and READY. Reset high: state to CLEAR (or READY if CLEAR_ON_RESET=0), ClearIndex to 0, ReadData to 0, ReadValid to 0, AddressError to 0.
- CLEAR with Reset low: each edge writes 0 to mem[ClearIndex] and increments ClearIndex. The edge that writes index DEPTH-1 moves to READY. Busy = (state == CLEAR).
- Reset asserted mid-sweep restarts the sweep at index 0.
- Requests (read, write, errors) presented while Busy are dropped with no side effects.
- Alignment: half needs Address[0]=0. Word needs Address[1:0]=00. Size 11 is always an error.
  - An erroneous request performs no write and no ReadData update. It sets AddressError=1 and ReadValid=0.
- Store, little-endian lanes:
  - Byte: lane Address[1:0] gets WriteData[7:0].
  - Half: lanes {Address[1],0} and {Address[1],1} get WriteData[15:0].
  - Word: all lanes.
  - Unselected lanes keep their contents.
- Load: select the lane(s) as for a store and right-justify the result. Bits above the loaded width come from the top loaded bit when LoadUnsigned=0, and are zero otherwise.
- MemoryRead and MemoryWrite both high: performs the write only, with ReadValid=0.
- With no valid read, ReadData holds its previous value and ReadValid=0.

## Timing
- Load latency is 1 cycle. A request sampled at edge k gives ReadData/ReadValid valid after edge k, for the following cycle only.
- A store at edge k is visible to a load sampled at edge k+1 or later. No same-edge forwarding is provided.
- AddressError is a single-cycle pulse after the offending edge.
- After Reset deasserts, Busy stays high for exactly DEPTH cycles, or 0 cycles when CLEAR_ON_RESET=0.
- Back-to-back requests are accepted every cycle while READY.

## Test plan
- Reset sweep: fill the memory with nonzero data, assert Reset 2 cycles, then release. Expect Busy high for exactly 64 cycles. Word loads of addresses 0x00 and 0xFC then return 0x00000000. A store issued during Busy is lost.
- Byte lanes: word store 0x11223344 @0x10, byte store 0xAA @0x12, word load @0x10. Expect 0x11AA3344.
- Sign extension: word store 0x80FF7F01 @0x20.
  - Signed byte load @0x22: 0xFFFFFFFF.
  - Unsigned byte load @0x22: 0x000000FF.
  - Signed half load @0x22: 0xFFFF80FF.
  - Signed byte load @0x20: 0x00000001.
- Misalignment: word store 0xDEADBEEF @0x31, half load @0x33, AccessSize=11 load @0x30. Expect AddressError pulsed each time, ReadValid=0, memory @0x30 unchanged.
- Back-to-back: store 0x5 @0x40 at edge k, word load @0x40 at edge k+1. Expect 0x00000005 with ReadValid=1 after k+1. Read and write both high at @0x44: write occurs, ReadValid=0.
- Reset mid-sweep: assert Reset at sweep index 30. Expect the sweep to restart and Busy to stay high a full 64 cycles after release.
